// File: rtl/stopwatch_display.sv
// stopwatch_display: converts binary minutes/seconds to BCD with a sequential
// double-dabble and drives a 4-digit common-anode multiplexed display as MM.SS.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   minutes[7:0]   - binary minutes 0..255
//   seconds[5:0]   - binary seconds 0..63
//   paused         - blink the colon when high, steady on when low
//   seg_n[6:0]     - segments {g,f,e,d,c,b,a}, active-low (combinational)
//   dp_n           - decimal point, active-low (combinational)
//   an_n[3:0]      - digit anodes, active-low one-hot (combinational)
//   digits[15:0]   - committed BCD {m_tens, m_ones, s_tens, s_ones}
//   min_ovf        - committed minutes value exceeded 99
module stopwatch_display #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  minutes,
    input  logic [5:0]  seconds,
    input  logic        paused,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic [15:0] digits,
    output logic        min_ovf
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {ST_LOAD, ST_SHIFT, ST_COMMIT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  shift_cnt, shift_cnt_nxt;
    // {hundreds, tens, ones, binary} for minutes; {tens, ones, binary} for seconds
    logic [19:0] min_sr, min_sr_nxt;
    logic [15:0] sec_sr, sec_sr_nxt;
    logic [15:0] digits_nxt;
    logic        min_ovf_nxt;

    logic [PW-1:0] presc;
    logic [FW-1:0] frame;
    logic [1:0]    idx;
    logic          blink_ph;
    logic [3:0]    nib;

    // One double-dabble step: correct BCD nibbles >= 5, then shift left
    function automatic logic [19:0] dabble_min(input logic [19:0] sr);
        logic [19:0] a;
        a = sr;
        for (int i = 0; i < 3; i++) begin
            if (a[8 + 4*i +: 4] >= 4'd5) a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
        end
        return {a[18:0], 1'b0};
    endfunction

    function automatic logic [15:0] dabble_sec(input logic [15:0] sr);
        logic [15:0] a;
        a = sr;
        for (int i = 0; i < 2; i++) begin
            if (a[8 + 4*i +: 4] >= 4'd5) a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
        end
        return {a[14:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Converter state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD;
            shift_cnt <= 3'd0;
            min_sr    <= 20'd0;
            sec_sr    <= 16'd0;
            digits    <= 16'h0000;
            min_ovf   <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_cnt <= shift_cnt_nxt;
            min_sr    <= min_sr_nxt;
            sec_sr    <= sec_sr_nxt;
            digits    <= digits_nxt;
            min_ovf   <= min_ovf_nxt;
        end
    end

    // Converter next-state: LOAD -> SHIFT x8 -> COMMIT -> LOAD
    always_comb begin
        state_nxt     = state;
        shift_cnt_nxt = shift_cnt;
        min_sr_nxt    = min_sr;
        sec_sr_nxt    = sec_sr;
        digits_nxt    = digits;
        min_ovf_nxt   = min_ovf;
        case (state)
            ST_LOAD: begin
                min_sr_nxt    = {12'd0, minutes};
                sec_sr_nxt    = {8'd0, 2'b00, seconds};
                shift_cnt_nxt = 3'd0;
                state_nxt     = ST_SHIFT;
            end
            ST_SHIFT: begin
                min_sr_nxt    = dabble_min(min_sr);
                sec_sr_nxt    = dabble_sec(sec_sr);
                shift_cnt_nxt = shift_cnt + 3'd1;
                if (shift_cnt == 3'd7) state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (min_sr[19:16] != 4'd0) begin
                    digits_nxt[15:8] = 8'h99;
                    min_ovf_nxt      = 1'b1;
                end else begin
                    digits_nxt[15:8] = min_sr[15:8];
                    min_ovf_nxt      = 1'b0;
                end
                digits_nxt[7:0] = sec_sr[15:8];
                state_nxt       = ST_LOAD;
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // Digit scanner, frame counter and colon blink phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            idx      <= 2'd0;
            frame    <= '0;
            blink_ph <= 1'b0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= idx + 2'd1;
            if (idx == 2'd3) begin
                if (frame == FW'(BLINK_FRAMES - 1)) begin
                    frame    <= '0;
                    blink_ph <= ~blink_ph;
                end else begin
                    frame <= frame + FW'(1);
                end
            end
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Display decode of the selected digit
    always_comb begin
        case (idx)
            2'd0:    nib = digits[3:0];
            2'd1:    nib = digits[7:4];
            2'd2:    nib = digits[11:8];
            default: nib = digits[15:12];
        endcase
    end

    assign an_n  = ~(4'b0001 << idx);
    assign seg_n = seg_decode(nib);
    assign dp_n  = ~(((idx == 2'd2) && (!paused || !blink_ph)) ||
                     ((idx == 2'd3) && min_ovf));

endmodule

// File: tb/tb_stopwatch_display.sv
module tb_stopwatch_display;

    logic        clk;
    logic        rst_n;
    logic [7:0]  minutes;
    logic [5:0]  seconds;
    logic        paused;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  an_a, an_b;
    logic [15:0] dig_a, dig_b;
    logic        ovf_a, ovf_b;

    int passed = 0;
    int total  = 0;
    int ecnt   = 0;   // clock edges since reset release

    logic [6:0] seg_tab [16];

    typedef struct {
        logic [7:0]  m;
        logic [5:0]  s;
        logic [15:0] d;
        logic        ovf;
    } vec_t;

    vec_t vecs [11];

    // Scan/blink instance: frame 16 clocks, blink toggles every 16 clocks
    stopwatch_display #(.SCAN_DIV(4), .BLINK_FRAMES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .minutes(minutes), .seconds(seconds),
        .paused(paused), .seg_n(seg_a), .dp_n(dp_a), .an_n(an_a),
        .digits(dig_a), .min_ovf(ovf_a));

    // Scan/blink instance: frame 8 clocks, blink toggles every 16 clocks
    stopwatch_display #(.SCAN_DIV(2), .BLINK_FRAMES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .minutes(minutes), .seconds(seconds),
        .paused(paused), .seg_n(seg_b), .dp_n(dp_b), .an_n(an_b),
        .digits(dig_b), .min_ovf(ovf_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Park so that the next rising edge is a LOAD edge
    task automatic wait_load_pre();
        for (int i = 0; i < 10 && (ecnt % 10) != 0; i++) step();
    endtask

    function automatic logic [11:0] disp_exp(input int i, input logic [15:0] d,
                                             input logic ovf, input logic bl);
        logic [15:0] sh;
        logic [3:0]  nib;
        logic [3:0]  an;
        logic        dp;
        sh  = d >> (4 * i);
        nib = sh[3:0];
        an  = ~(4'b0001 << i);
        dp  = ~(((i == 2) && (!paused || !bl)) || ((i == 3) && ovf));
        return {an, seg_tab[nib], dp};
    endfunction

    task automatic check_disp(input logic [15:0] d, input logic ovf, input int n);
        logic bl;
        for (int c = 0; c < n; c++) begin
            bl = 1'((ecnt / 16) % 2);
            chk("disp_a", {20'd0, an_a, seg_a, dp_a}, {20'd0, disp_exp((ecnt / 4) % 4, d, ovf, bl)});
            chk("disp_b", {20'd0, an_b, seg_b, dp_b}, {20'd0, disp_exp((ecnt / 2) % 4, d, ovf, bl)});
            step();
        end
    endtask

    initial begin
        logic [15:0] prev;

        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111111;

        vecs[0]  = '{8'd0,   6'd0,  16'h0000, 1'b0};
        vecs[1]  = '{8'd42,  6'd37, 16'h4237, 1'b0};
        vecs[2]  = '{8'd100, 6'd5,  16'h9905, 1'b1};
        vecs[3]  = '{8'd255, 6'd59, 16'h9959, 1'b1};
        vecs[4]  = '{8'd99,  6'd0,  16'h9900, 1'b0};
        vecs[5]  = '{8'd9,   6'd59, 16'h0959, 1'b0};
        vecs[6]  = '{8'd9,   6'd60, 16'h0960, 1'b0};
        vecs[7]  = '{8'd9,   6'd0,  16'h0900, 1'b0};
        vecs[8]  = '{8'd10,  6'd63, 16'h1063, 1'b0};
        vecs[9]  = '{8'd7,   6'd3,  16'h0703, 1'b0};
        vecs[10] = '{8'd15,  6'd48, 16'h1548, 1'b0};

        rst_n = 1'b0; minutes = 8'd0; seconds = 6'd0; paused = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_digits", {16'd0, dig_a}, 32'h0000);
        chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
        chk("rst_disp_a", {20'd0, an_a, seg_a, dp_a}, {20'd0, 4'b1110, 7'b1000000, 1'b1});
        chk("rst_disp_b", {20'd0, an_b, seg_b, dp_b}, {20'd0, 4'b1110, 7'b1000000, 1'b1});

        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) step();
        chk("idle_digits", {16'd0, dig_a}, 32'h0000);
        check_disp(16'h0000, 1'b0, 8);

        // Conversion vectors: value lands exactly on the COMMIT edge, 9 clocks after LOAD
        prev = 16'h0000;
        for (int v = 0; v < 11; v++) begin
            wait_load_pre();
            minutes = vecs[v].m;
            seconds = vecs[v].s;
            step();
            for (int k = 0; k < 8; k++) begin
                chk("hold_digits", {16'd0, dig_a}, {16'd0, prev});
                step();
            end
            chk("hold_digits_last", {16'd0, dig_a}, {16'd0, prev});
            step();
            chk("conv_digits", {16'd0, dig_a}, {16'd0, vecs[v].d});
            chk("conv_ovf", {31'd0, ovf_a}, {31'd0, vecs[v].ovf});
            chk("conv_digits_b", {16'd0, dig_b}, {16'd0, vecs[v].d});
            check_disp(vecs[v].d, vecs[v].ovf, 16);
            prev = vecs[v].d;
        end

        // Colon blink while paused, steady while running
        paused = 1'b1;
        check_disp(prev, 1'b0, 64);
        paused = 1'b0;
        check_disp(prev, 1'b0, 32);

        // Reset in the middle of SHIFT discards the conversion
        wait_load_pre();
        minutes = 8'd77;
        seconds = 6'd12;
        step();
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_digits", {16'd0, dig_a}, 32'h0000);
        chk("midrst_ovf", {31'd0, ovf_a}, 32'd0);
        repeat (12) @(negedge clk);
        chk("midrst_hold", {16'd0, dig_a}, 32'h0000);
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("postrst_hold", {16'd0, dig_a}, 32'h0000);
        end
        step();
        chk("postrst_digits", {16'd0, dig_a}, 32'h7712);
        check_disp(16'h7712, 1'b0, 16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
